imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the decode stage.
- Decodes the opcode of each incoming instruction and classifies its format (I/S/B/U/J/none).
- Produces the sign-extended immediate at parametrised width XLEN and flags unsupported opcodes.
- A 2-entry skid buffer decouples the fetch/decode valid-ready handshake from the execute side, so back-pressure never drops or duplicates instructions.

Parameters:
- XLEN, 32: immediate output width; legal values 32 or 64; sign-extend from the format's top bit (instr[31]) to XLEN.
- TAG_W, 32: width of the sideband tag (typically the PC), carried unmodified alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  raw instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts this cycle.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 unused.
- out_illegal  output  1  unsupported opcode or instr[1:0] != 2'b11.
- out_tag  output  TAG_W  tag of the presented result.

Behaviour:
- Opcode decode (instr[6:0]):
  - I: 0000011 load, 0010011 OP-IMM, 1100111 JALR, 0001111 FENCE, 1110011 SYSTEM.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111 LUI, 0010111 AUIPC.
  - J: 1101111 JAL.
  - NONE: 0110011 (R-type); imm 0, illegal 0.
  - Any other opcode, or instr[1:0] != 11: fmt NONE, imm 0, illegal 1.
- Immediate assembly before extension to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}; for XLEN=64, sign-extend from bit 31.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Shift-immediate (SLLI/SRLI/SRAI) is treated as plain I-format; no special handling.
- Storage: an output register (O) and a skid register (K). Each holds {imm, fmt, illegal, tag} plus a valid bit.
- States, encoded by {K.valid, O.valid}:
  - EMPTY (0,0): in_ready=1.
  - ONE (0,1): in_ready=1.
  - FULL (1,1): in_ready=0.
  - (1,0) is unreachable; the bench asserts this.
- Handshake rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready is driven from registered state only; it has no combinational path from out_ready.
  - in_ready is forced to 0 while rst is high.
- Transitions:
  - EMPTY + input → ONE; O is loaded with the decoded input.
  - ONE + output, no input → EMPTY.
  - ONE + input + output → ONE; O is reloaded with the new input.
  - ONE + input, no output → FULL; the input goes to K.
  - FULL + output → ONE; O <= K, K is cleared.
  - FULL blocks input (in_ready=0).
- Latency: 1 cycle from input transfer to out_valid when not back-pressured; sustained throughput is 1 per cycle.
- Ordering: strict FIFO; no loss, no duplication.
- out_* data must be stable while out_valid=1 and out_ready=0.
- Reset: asserted asynchronously, any state → EMPTY.
  - out_valid=0, in_ready=0 while rst is asserted; in_ready=1 in the first cycle after deassertion.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - Any in-flight entries are discarded.
- X inputs while in_valid=0 must not propagate to out_* when out_valid=0; data registers load only on transfer.

Test Plan:
- I-format: send 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, illegal=0, tag echoed.
- B/U/J formats back-to-back:
  - 0xFE000FE3 → imm=0xFFFFFFFE, fmt=3.
  - 0x123450B7 → imm=0x12345000, fmt=4.
  - 0xFFDFF06F → imm=0xFFFFFFFC, fmt=5.
  - Required: one result per cycle, order preserved.
- S and R/illegal:
  - 0xFE112E23 (sw x1,-4(x2)) → imm=0xFFFFFFFC, fmt=2.
  - 0x002081B3 (add) → fmt=0, illegal=0.
  - 0x0000007F → fmt=0, imm=0, illegal=1.
- Back-pressure: hold out_ready=0 and offer 3 instructions on consecutive cycles.
  - First two are accepted; in_ready=0 from the cycle after the second is accepted.
  - out_* stay stable while stalled.
  - Releasing out_ready drains all in order; the third is accepted once in_ready returns; no loss, no duplication.
- Reset in FULL state: assert rst mid-cycle → out_valid drops immediately (async), in_ready=0 during reset, =1 after release; no stale result appears afterwards.
- XLEN=64 build:
  - 0xFFF00093 → imm=0xFFFFFFFFFFFFFFFF.
  - 0x800000B7 (lui x1,0x80000) → imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: classifies the instruction format, sign-extends
// the immediate to XLEN, and presents results through a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2,
                         F_B    = 3'd3, F_U = 3'd4, F_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } ent_t;

  // State bits are {K.valid, O.valid}; 2'b10 is never entered.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_e;

  state_e      state_q, state_d;
  ent_t        o_q, o_d, k_q, k_d, dec;
  logic [31:0] imm32;
  logic        in_xfer, out_xfer;

  // Every supported opcode has [1:0]=11, so the default arm also covers bad low bits.
  always_comb begin
    imm32       = '0;
    dec.fmt     = F_NONE;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        dec.fmt = F_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = F_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = F_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = F_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = F_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    dec.tag = in_tag;
  end

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready = (state_q != FULL) & ~rst;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    k_d     = k_q;
    case (state_q)
      EMPTY: if (in_xfer) begin
        o_d     = dec;
        state_d = ONE;
      end
      ONE: begin
        if (in_xfer && out_xfer) o_d = dec;
        else if (in_xfer) begin
          k_d     = dec;
          state_d = FULL;
        end else if (out_xfer) state_d = EMPTY;
      end
      FULL: if (out_xfer) begin
        o_d     = k_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      o_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      k_q     <= k_d;
    end
  end

  assign out_valid   = state_q[0];
  assign out_imm     = o_q.imm;
  assign out_fmt     = o_q.fmt;
  assign out_illegal = o_q.illegal;
  assign out_tag     = o_q.tag;

endmodule
